// File: rtl/tpu_pkg.sv
// Shared constants for the systolic array datapath: default widths and
// element-slice helpers used by the output de-skew stage.
package tpu_pkg;

  localparam int DATA_SIZE  = 8;
  localparam int MAC_WIDTH  = 16;
  localparam int ACC_WIDTH  = 32;
  localparam int OUT_WIDTH  = 8;
  localparam int FIFO_DEPTH = 32;

  // Low bit of element idx in a flat vector of width-bit elements.
  function automatic int elem_lo(input int idx, input int width);
    return idx * width;
  endfunction

  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int sat_min(input int width);
    return -(1 << (width - 1));
  endfunction

endpackage

// File: rtl/systolic_deskew_out_if.sv
// Stream bundle of the output de-skew stage: skewed accumulator columns in,
// aligned narrowed rows out, plus flow-control status.
interface systolic_deskew_out_if #(
  parameter int MAC_WIDTH = tpu_pkg::MAC_WIDTH,
  parameter int ACC_WIDTH = tpu_pkg::ACC_WIDTH,
  parameter int OUT_WIDTH = tpu_pkg::OUT_WIDTH
);

  logic                           in_valid;
  logic [MAC_WIDTH*ACC_WIDTH-1:0] in_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [MAC_WIDTH*OUT_WIDTH-1:0] out_data;
  logic                           out_last;
  logic                           almost_full;
  logic                           overflow;
  logic                           tile_done;

  // Environment side: feeds the skewed columns and consumes rows.
  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_last, almost_full, overflow, tile_done
  );

  // De-skew block side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_last, almost_full, overflow, tile_done
  );

endinterface

// File: rtl/deskew_row_fifo.sv
// First-word-fall-through row FIFO with occupancy count; DEPTH must be a
// power of two so the pointers wrap for free.
module deskew_row_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a row when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    // NOTE: assign the default first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign count    = count_q;

endmodule

// File: rtl/systolic_deskew_out.sv
// Output de-skew stage: re-aligns skewed MAC result columns, narrows each
// element, tags tile rows and buffers them. Define DESKEW_SAT_EN to saturate.
module systolic_deskew_out #(
  parameter int MAC_WIDTH  = tpu_pkg::MAC_WIDTH,
  parameter int ACC_WIDTH  = tpu_pkg::ACC_WIDTH,
  parameter int OUT_WIDTH  = tpu_pkg::OUT_WIDTH,
  parameter int FIFO_DEPTH = tpu_pkg::FIFO_DEPTH
) (
  input logic                  clock,
  input logic                  reset,
  systolic_deskew_out_if.slave bus
);

  localparam int ROW_W = MAC_WIDTH * OUT_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TAG_W = $clog2(MAC_WIDTH);

  logic [MAC_WIDTH*ACC_WIDTH-1:0] aligned_row;
  logic [ROW_W-1:0]               narrow_row;
  logic [MAC_WIDTH-2:0]           valid_pipe;
  logic                           aligned_valid;
  logic [TAG_W-1:0]               row_cnt;
  logic                           row_last;

  logic                           wr_valid;
  logic                           wr_last;
  logic [ROW_W-1:0]               wr_row;

  logic [ROW_W:0]                 head_entry;
  logic                           head_last;
  logic [ROW_W-1:0]               head_row;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic [CNT_W-1:0]               fifo_count;
  logic                           pop;

  logic [ROW_W-1:0]               shown_row;
  logic                           overflow_q;
  logic                           tile_done_q;

  // Column j arrives j cycles after column 0, so it waits MAC_WIDTH-1-j cycles.
  for (genvar j = 0; j < MAC_WIDTH; j++) begin : g_col
    localparam int LO    = tpu_pkg::elem_lo(j, ACC_WIDTH);
    localparam int TAP_N = MAC_WIDTH - 1 - j;
    if (TAP_N == 0) begin : g_direct
      assign aligned_row[LO +: ACC_WIDTH] = bus.in_data[LO +: ACC_WIDTH];
    end else begin : g_delay
      logic [ACC_WIDTH-1:0] taps [TAP_N];
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < TAP_N; k++) taps[k] <= '0;
        end else begin
          taps[0] <= bus.in_data[LO +: ACC_WIDTH];
          for (int k = 1; k < TAP_N; k++) taps[k] <= taps[k-1];
        end
      end
      assign aligned_row[LO +: ACC_WIDTH] = taps[TAP_N-1];
    end
  end

`ifdef DESKEW_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(tpu_pkg::sat_max(OUT_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(tpu_pkg::sat_min(OUT_WIDTH));

  for (genvar j = 0; j < MAC_WIDTH; j++) begin : g_narrow
    logic signed [ACC_WIDTH-1:0] elem;
    assign elem = aligned_row[tpu_pkg::elem_lo(j, ACC_WIDTH) +: ACC_WIDTH];
    assign narrow_row[tpu_pkg::elem_lo(j, OUT_WIDTH) +: OUT_WIDTH] =
      (elem > SAT_MAX) ? SAT_MAX[OUT_WIDTH-1:0] :
      (elem < SAT_MIN) ? SAT_MIN[OUT_WIDTH-1:0] :
                         elem[OUT_WIDTH-1:0];
  end
`else
  for (genvar j = 0; j < MAC_WIDTH; j++) begin : g_narrow
    assign narrow_row[tpu_pkg::elem_lo(j, OUT_WIDTH) +: OUT_WIDTH] =
      aligned_row[tpu_pkg::elem_lo(j, ACC_WIDTH) +: OUT_WIDTH];
  end
  // Truncation discards the upper accumulator bits.
  logic unused_hi_bits;
  assign unused_hi_bits = ^aligned_row;
`endif

  assign aligned_valid = valid_pipe[MAC_WIDTH-2];
  assign row_last      = (row_cnt == TAG_W'(MAC_WIDTH - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_pipe <= '0;
      row_cnt    <= '0;
    end else begin
      // NOTE: non-blocking so each stage captures its neighbour's pre-edge value.
      valid_pipe[0] <= bus.in_valid;
      for (int k = 1; k < MAC_WIDTH - 1; k++) valid_pipe[k] <= valid_pipe[k-1];
      // Counts dropped rows too, keeping tile alignment after an overflow.
      if (aligned_valid) row_cnt <= row_last ? '0 : row_cnt + 1'b1;
    end
  end

  // Write stage: one register between the aligned row and the FIFO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_valid <= 1'b0;
      wr_last  <= 1'b0;
      wr_row   <= '0;
    end else begin
      wr_valid <= aligned_valid;
      if (aligned_valid) begin
        wr_last <= row_last;
        wr_row  <= narrow_row;
      end
    end
  end

  deskew_row_fifo #(
    .WIDTH (ROW_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wr_valid),
    .push_data ({wr_last, wr_row}),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_last = head_entry[ROW_W];
  assign head_row  = head_entry[ROW_W-1:0];
  assign pop       = !fifo_empty && bus.out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shown_row   <= '0;
      overflow_q  <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      if (pop) shown_row <= head_row;
      if (wr_valid && fifo_full && !pop) overflow_q <= 1'b1;
      tile_done_q <= pop && head_last;
    end
  end

  assign bus.out_valid   = !fifo_empty;
  // While empty the port keeps showing the most recently popped row.
  assign bus.out_data    = fifo_empty ? shown_row : head_row;
  assign bus.out_last    = !fifo_empty && head_last;
  assign bus.almost_full = (fifo_count >= CNT_W'(FIFO_DEPTH - MAC_WIDTH));
  assign bus.overflow    = overflow_q;
  assign bus.tile_done   = tile_done_q;

endmodule

// File: tb/tb_systolic_deskew_out.sv
// Self-checking bench for systolic_deskew_out: queue-based row model plus
// literal checks for latency, tagging, full/overflow, narrowing and reset.
module tb_systolic_deskew_out;

  localparam int MW    = 4;
  localparam int AW    = 32;
  localparam int OW    = 8;
  localparam int DEPTH = 8;
  localparam int RW    = MW * OW;
  localparam int HIST  = 2048;

  logic clock = 1'b0;
  logic reset = 1'b1;

  systolic_deskew_out_if #(.MAC_WIDTH(MW), .ACC_WIDTH(AW), .OUT_WIDTH(OW)) bus ();

  systolic_deskew_out #(
    .MAC_WIDTH (MW),
    .ACC_WIDTH (AW),
    .OUT_WIDTH (OW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct { logic [RW-1:0] row; bit last; } entry_t;
  typedef struct { int due; entry_t e; } arrival_t;

  entry_t   mq[$];
  arrival_t arr_q[$];
  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int row_idx = 0;
  bit m_ovf = 1'b0;
  bit m_tdone = 1'b0;
  logic [RW-1:0] m_last_popped = '0;
  logic [AW-1:0] nxt [MW];
  logic [AW-1:0] hist_acc [HIST][MW];
  bit            hist_v [HIST];
  int n_valid = 0, n_last = 0, n_tdone = 0, n_pops = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] m_narrow(input logic [AW-1:0] a);
`ifdef DESKEW_SAT_EN
    int s;
    s = $signed(a);
    if (s > (1 << (OW-1)) - 1) return OW'((1 << (OW-1)) - 1);
    if (s < -(1 << (OW-1)))    return OW'(1 << (OW-1));
    return a[OW-1:0];
`else
    return a[OW-1:0];
`endif
  endfunction

  function automatic logic [RW-1:0] m_row();
    logic [RW-1:0] r;
    for (int j = 0; j < MW; j++) r[j*OW +: OW] = m_narrow(nxt[j]);
    return r;
  endfunction

  // One clock edge of the abstract model: pop, then the arriving row, then a new issue.
  task automatic model_update(input bit v, input bit rdy);
    int pre;
    bit popped, td;
    arrival_t a;
    entry_t ne;
    pre = mq.size();
    popped = (pre > 0) && rdy;
    td = 1'b0;
    if (popped) begin
      td = mq[0].last;
      m_last_popped = mq[0].row;
      void'(mq.pop_front());
      n_pops++;
    end
    if (arr_q.size() > 0 && arr_q[0].due == edge_n) begin
      a = arr_q.pop_front();
      if (pre < DEPTH || popped) mq.push_back(a.e);
      else m_ovf = 1'b1;
    end
    if (v) begin
      ne.row  = m_row();
      ne.last = (row_idx % MW) == MW - 1;
      row_idx++;
      a.due = edge_n + MW;
      a.e   = ne;
      arr_q.push_back(a);
    end
    m_tdone = td;
  endtask

  task automatic compare_all();
    bit mv;
    mv = mq.size() > 0;
    check("out_valid", 64'(bus.out_valid), 64'(mv));
    if (mv) begin
      check("out_data", 64'(bus.out_data), 64'(mq[0].row));
      check("out_last", 64'(bus.out_last), 64'(mq[0].last));
      n_valid++;
      if (bus.out_last) n_last++;
    end else begin
      check("out_data_hold", 64'(bus.out_data), 64'(m_last_popped));
    end
    check("almost_full", 64'(bus.almost_full), 64'(mq.size() >= DEPTH - MW));
    check("overflow", 64'(bus.overflow), 64'(m_ovf));
    check("tile_done", 64'(bus.tile_done), 64'(m_tdone));
    if (bus.tile_done) n_tdone++;
  endtask

  // Drives one cycle (column j carries the row issued j edges earlier), then checks.
  task automatic step(input bit v, input bit rdy);
    logic [MW*AW-1:0] d;
    int e, src;
    e = edge_n + 1;
    hist_v[e] = v && reset;
    if (v) for (int j = 0; j < MW; j++) hist_acc[e][j] = nxt[j];
    for (int j = 0; j < MW; j++) begin
      src = e - j;
      if (src >= 0 && hist_v[src]) d[j*AW +: AW] = hist_acc[src][j];
      else d[j*AW +: AW] = $urandom;
    end
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = rdy;
    @(posedge clock);
    edge_n = e;
    if (reset) model_update(v, rdy);
    #1 compare_all();
    @(negedge clock);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, rdy);
  endtask

  task automatic rand_row();
    for (int j = 0; j < MW; j++) begin
      if ($urandom_range(3) == 0) nxt[j] = $urandom;
      else nxt[j] = AW'($signed($urandom_range(600)) - 300);
    end
  endtask

  task automatic do_reset(input bit pin);
    reset = 1'b0;
    #1;
    if (pin) begin
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_data", 64'(bus.out_data), 64'd0);
      check("rst_out_last", 64'(bus.out_last), 64'd0);
      check("rst_almost_full", 64'(bus.almost_full), 64'd0);
      check("rst_overflow", 64'(bus.overflow), 64'd0);
      check("rst_tile_done", 64'(bus.tile_done), 64'd0);
    end
    mq.delete();
    arr_q.delete();
    row_idx = 0;
    m_ovf = 1'b0;
    m_tdone = 1'b0;
    m_last_popped = '0;
    idle(2, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1;
    do_reset(1'b1);

    // Single skewed row 10..13: visible after the fourth edge.
    for (int j = 0; j < MW; j++) nxt[j] = AW'(10 + j);
    step(1'b1, 1'b0);
    idle(3, 1'b0);
    check("lat_not_yet", 64'(bus.out_valid), 64'd0);
    step(1'b0, 1'b0);
    check("lat_valid", 64'(bus.out_valid), 64'd1);
    check("lat_data", 64'(bus.out_data), 64'h0D0C0B0A);
    check("lat_last", 64'(bus.out_last), 64'd0);
    idle(2, 1'b1);

    // Finish the tile, then one whole tile back-to-back.
    for (int i = 0; i < 3; i++) begin rand_row(); step(1'b1, 1'b1); end
    idle(8, 1'b1);
    n_valid = 0; n_last = 0; n_tdone = 0;
    for (int i = 0; i < MW; i++) begin rand_row(); step(1'b1, 1'b1); end
    idle(8, 1'b1);
    check("burst_valid_cycles", 64'(n_valid), 64'd4);
    check("burst_last_rows", 64'(n_last), 64'd1);
    check("burst_tile_done", 64'(n_tdone), 64'd1);

    // Fill to exactly full, then push and pop together on every edge.
    for (int i = 0; i < DEPTH; i++) begin rand_row(); step(1'b1, 1'b0); end
    idle(6, 1'b0);
    check("full_almost_full", 64'(bus.almost_full), 64'd1);
    check("full_no_overflow", 64'(bus.overflow), 64'd0);
    for (int k = 0; k < 10; k++) begin rand_row(); step(k < 6, (k >= 4)); end
    check("pushpop_no_overflow", 64'(bus.overflow), 64'd0);
    check("pushpop_almost_full", 64'(bus.almost_full), 64'd1);
    idle(12, 1'b1);
    check("drained_empty", 64'(bus.out_valid), 64'd0);

    // Overrun a stalled FIFO.
    for (int i = 0; i < 14; i++) begin rand_row(); step(1'b1, 1'b0); end
    idle(6, 1'b0);
    check("ovf_set", 64'(bus.overflow), 64'd1);
    n_pops = 0;
    idle(12, 1'b1);
    check("ovf_drain_rows", 64'(n_pops), 64'(DEPTH));
    check("ovf_sticky", 64'(bus.overflow), 64'd1);
    check("ovf_drained", 64'(bus.out_valid), 64'd0);

    // Narrowing corner values.
    do_reset(1'b0);
    check("ovf_cleared", 64'(bus.overflow), 64'd0);
    nxt[0] = 32'h0000_0180; nxt[1] = 32'hFFFF_FF00;
    nxt[2] = 32'h0000_007F; nxt[3] = 32'hFFFF_FF80;
    step(1'b1, 1'b0);
    idle(4, 1'b0);
`ifdef DESKEW_SAT_EN
    check("narrow_row", 64'(bus.out_data), 64'h807F807F);
`else
    check("narrow_row", 64'(bus.out_data), 64'h807F0080);
`endif
    idle(2, 1'b1);

    // Reset mid-tile with three rows buffered; next row restarts the tile.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin rand_row(); step(1'b1, 1'b0); end
    idle(5, 1'b0);
    check("midtile_buffered", 64'(bus.out_valid), 64'd1);
    do_reset(1'b1);
    rand_row();
    step(1'b1, 1'b0);
    idle(4, 1'b0);
    check("post_rst_valid", 64'(bus.out_valid), 64'd1);
    check("post_rst_row0_tag", 64'(bus.out_last), 64'd0);
    check("post_rst_overflow", 64'(bus.overflow), 64'd0);
    idle(2, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rand_row();
      step($urandom_range(99) < 60, $urandom_range(99) < 70);
    end
    idle(20, 1'b1);
    check("final_empty", 64'(bus.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
